// File: rtl/regfile_pkg.sv
// Shared defaults and address type for the 2-read/1-write register file.
package regfile_pkg;

  localparam int REGFILE_WIDTH = 64;
  localparam int REGFILE_DEPTH = 32;
  localparam int REGFILE_AW    = $clog2(REGFILE_DEPTH);

  typedef logic [REGFILE_AW-1:0] reg_addr_t;

  // Address width for a given depth; a single-entry file still needs one address bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_word.sv
// One storage word: WIDTH-bit enabled register, asynchronous active-high clear.
module regfile_word
  import regfile_pkg::*;
#(
  parameter int WIDTH = REGFILE_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // Capture write data when enabled; reset clears regardless of the clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Register file with two combinational read ports, one write port, optional
// write-to-read forwarding, optional hardwired zero register, and a per-register
// busy scoreboard (set by issue, cleared by write).
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = REGFILE_WIDTH,
  parameter  int DEPTH    = REGFILE_DEPTH,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = addr_width(DEPTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             WE,
  input  logic [AW-1:0]    WADDR,
  input  logic [WIDTH-1:0] WDATA,
  input  logic [AW-1:0]    RADDR1,
  input  logic [AW-1:0]    RADDR2,
  output logic [WIDTH-1:0] RDATA1,
  output logic [WIDTH-1:0] RDATA2,
  output logic             RBUSY1,
  output logic             RBUSY2,
  input  logic             ISSUE_EN,
  input  logic [AW-1:0]    ISSUE_ADDR
);

  // An address is live if it maps to a real register that is not the hardwired zero.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < 32'(DEPTH)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic             wr_ok;
  logic             iss_ok;
  logic [DEPTH-1:0] word_we;
  logic [WIDTH-1:0] word_rd [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [AW-1:0]    raddr   [2];
  logic [WIDTH-1:0] rdata   [2];
  logic             rbusy   [2];

  assign wr_ok  = WE && addr_ok(WADDR);
  assign iss_ok = ISSUE_EN && addr_ok(ISSUE_ADDR);

  // One-hot write enable for the addressed word; dead addresses enable nothing.
  always_comb begin
    word_we = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr_ok && (WADDR == AW'(i))) begin
        word_we[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    regfile_word #(
      .WIDTH(WIDTH)
    ) u_word (
      .clk_i(CLK),
      .rst_i(Reset),
      .en_i (word_we[g]),
      .d_i  (WDATA),
      .q_o  (word_rd[g])
    );
  end

  // Scoreboard next state: a write retires its producer, a same-edge issue re-arms it.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr_ok && (WADDR == AW'(i))) begin
        busy_d[i] = 1'b0;
      end
      if (iss_ok && (ISSUE_ADDR == AW'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  // Busy bits, cleared asynchronously with the storage.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign raddr[0] = RADDR1;
  assign raddr[1] = RADDR2;

  // Read muxes: stored value or forwarded write data, busy masked by a retiring write.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rdata[p] = '0;
      rbusy[p] = 1'b0;
      if (addr_ok(raddr[p])) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (raddr[p] == AW'(i)) begin
            if ((BYPASS != 0) && wr_ok && (WADDR == raddr[p])) begin
              rdata[p] = WDATA;
              rbusy[p] = busy_q[i] && iss_ok && (ISSUE_ADDR == raddr[p]);
            end else begin
              rdata[p] = word_rd[i];
              rbusy[p] = busy_q[i];
            end
          end
        end
      end
    end
  end

  assign RDATA1 = rdata[0];
  assign RDATA2 = rdata[1];
  assign RBUSY1 = rbusy[0];
  assign RBUSY2 = rbusy[1];

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: two instances (forwarding/zero-reg/full depth, and
// no-forwarding/no-zero-reg/24 entries) driven by the same stimulus and checked
// against an array-based model every cycle, plus directed literal checks.
module tb_regfile_2r1w;
  import regfile_pkg::*;

  localparam int W = 64;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        WE = 1'b0;
  logic        ISSUE_EN = 1'b0;
  reg_addr_t   WADDR = '0;
  reg_addr_t   ISSUE_ADDR = '0;
  reg_addr_t   RADDR1 = '0;
  reg_addr_t   RADDR2 = '0;
  logic [W-1:0] WDATA = '0;

  logic [W-1:0] rd1 [2];
  logic [W-1:0] rd2 [2];
  logic         rb1 [2];
  logic         rb2 [2];

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  regfile_2r1w #(.WIDTH(64), .DEPTH(32), .BYPASS(1), .ZERO_REG(1)) u_dut_a (
    .CLK(CLK), .Reset(Reset), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .RADDR1(RADDR1), .RADDR2(RADDR2), .RDATA1(rd1[0]), .RDATA2(rd2[0]),
    .RBUSY1(rb1[0]), .RBUSY2(rb2[0]), .ISSUE_EN(ISSUE_EN), .ISSUE_ADDR(ISSUE_ADDR)
  );

  regfile_2r1w #(.WIDTH(64), .DEPTH(24), .BYPASS(0), .ZERO_REG(0)) u_dut_b (
    .CLK(CLK), .Reset(Reset), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .RADDR1(RADDR1), .RADDR2(RADDR2), .RDATA1(rd1[1]), .RDATA2(rd2[1]),
    .RBUSY1(rb1[1]), .RBUSY2(rb2[1]), .ISSUE_EN(ISSUE_EN), .ISSUE_ADDR(ISSUE_ADDR)
  );

  // ---------------- reference model ----------------
  logic [W-1:0] mem [2][32];
  logic         bsy [2][32];

  function automatic int dep(input int k);
    return (k == 0) ? 32 : 24;
  endfunction

  function automatic bit byp(input int k);
    return k == 0;
  endfunction

  function automatic bit zr(input int k);
    return k == 0;
  endfunction

  function automatic bit ok(input int k, input reg_addr_t a);
    return (int'(a) < dep(k)) && !(zr(k) && (a == 0));
  endfunction

  function automatic logic [W-1:0] m_rdata(input int k, input reg_addr_t a);
    if (!ok(k, a)) return '0;
    if (byp(k) && WE && (WADDR == a)) return WDATA;
    return mem[k][a];
  endfunction

  function automatic logic m_busy(input int k, input reg_addr_t a);
    if (!ok(k, a)) return 1'b0;
    if (byp(k) && WE && (WADDR == a) && !(ISSUE_EN && (ISSUE_ADDR == a))) return 1'b0;
    return bsy[k][a];
  endfunction

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 32; i++) begin
          mem[k][i] <= '0;
          bsy[k][i] <= 1'b0;
        end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (WE && ok(k, WADDR)) begin
          mem[k][WADDR] <= WDATA;
          if (!(ISSUE_EN && ISSUE_ADDR == WADDR)) bsy[k][WADDR] <= 1'b0;
        end
        if (ISSUE_EN && ok(k, ISSUE_ADDR)) bsy[k][ISSUE_ADDR] <= 1'b1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare; while in reset a read may show 0 instead of forwarded data.
  always @(negedge CLK) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [W-1:0] e1, e2;
        e1 = m_rdata(k, RADDR1);
        e2 = m_rdata(k, RADDR2);
        if (Reset && rd1[k] == '0) e1 = '0;
        if (Reset && rd2[k] == '0) e2 = '0;
        chk($sformatf("rdata1[%0d]", k), rd1[k], e1);
        chk($sformatf("rdata2[%0d]", k), rd2[k], e2);
        chk($sformatf("rbusy1[%0d]", k), W'(rb1[k]), W'(m_busy(k, RADDR1)));
        chk($sformatf("rbusy2[%0d]", k), W'(rb2[k]), W'(m_busy(k, RADDR2)));
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    @(negedge CLK);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 Reset = 1'b1;
    RADDR1 = 5;
    RADDR2 = 31;
    repeat (2) @(posedge CLK);
    settle();
    for (int k = 0; k < 2; k++) begin
      chk("reset_rd1", rd1[k], '0);
      chk("reset_rd2", rd2[k], '0);
      chk("reset_rb1", W'(rb1[k]), '0);
      chk("reset_rb2", W'(rb2[k]), '0);
    end
    Reset = 1'b0;
    chk_en = 1'b1;

    // forwarding vs registered read
    step();
    WE = 1; WADDR = 7; WDATA = 64'hDEADBEEF_00000001; RADDR1 = 7;
    settle();
    chk("fwd_a", rd1[0], 64'hDEADBEEF_00000001);
    chk("nofwd_b", rd1[1], 64'h0);
    step();
    WE = 0;
    settle();
    chk("stored_a", rd1[0], 64'hDEADBEEF_00000001);
    chk("stored_b", rd1[1], 64'hDEADBEEF_00000001);

    // zero register
    step();
    WE = 1; WADDR = 0; WDATA = 64'hFFFF; ISSUE_EN = 1; ISSUE_ADDR = 0; RADDR1 = 0;
    settle();
    chk("zero_rd_same", rd1[0], 64'h0);
    chk("zero_rb_same", W'(rb1[0]), 64'h0);
    step();
    WE = 0; ISSUE_EN = 0;
    settle();
    chk("zero_rd_a", rd1[0], 64'h0);
    chk("zero_rb_a", W'(rb1[0]), 64'h0);
    chk("reg0_rd_b", rd1[1], 64'hFFFF);
    chk("reg0_rb_b", W'(rb1[1]), 64'h1);

    // scoreboard
    step();
    ISSUE_EN = 1; ISSUE_ADDR = 3; RADDR1 = 3;
    settle();
    chk("issue_not_yet", W'(rb1[0]), 64'h0);
    step();
    ISSUE_EN = 0;
    settle();
    chk("issue_set_a", W'(rb1[0]), 64'h1);
    chk("issue_set_b", W'(rb1[1]), 64'h1);
    step();
    WE = 1; WADDR = 3; WDATA = 64'h33;
    settle();
    chk("wr_fwd_busy_a", W'(rb1[0]), 64'h0);
    chk("wr_nofwd_busy_b", W'(rb1[1]), 64'h1);
    step();
    WE = 0;
    settle();
    chk("wr_clear_a", W'(rb1[0]), 64'h0);
    chk("wr_clear_b", W'(rb1[1]), 64'h0);
    chk("wr_data_b", rd1[1], 64'h33);
    step();
    WE = 1; WADDR = 3; WDATA = 64'h44; ISSUE_EN = 1; ISSUE_ADDR = 3;
    settle();
    chk("iss_wr_same_rb_a", W'(rb1[0]), 64'h0);
    chk("iss_wr_same_rd_a", rd1[0], 64'h44);
    step();
    WE = 0; ISSUE_EN = 0;
    settle();
    chk("iss_wins_a", W'(rb1[0]), 64'h1);
    chk("iss_wins_b", W'(rb1[1]), 64'h1);

    // out-of-range addresses on the 24-entry instance
    step();
    WE = 1; WADDR = 26; WDATA = 64'hAA; ISSUE_EN = 1; ISSUE_ADDR = 26; RADDR2 = 26;
    settle();
    chk("oor_rd_b", rd2[1], 64'h0);
    chk("inrange_fwd_a", rd2[0], 64'hAA);
    step();
    WE = 0; ISSUE_EN = 0;
    settle();
    chk("oor_rd_b2", rd2[1], 64'h0);
    chk("oor_rb_b2", W'(rb2[1]), 64'h0);
    chk("inrange_rd_a", rd2[0], 64'hAA);
    chk("inrange_rb_a", W'(rb2[0]), 64'h1);

    // asynchronous reset mid-cycle
    step();
    WE = 1; WADDR = 9; WDATA = 64'h1234; RADDR1 = 9;
    step();
    WE = 0;
    settle();
    chk("pre_rst_a", rd1[0], 64'h1234);
    chk("pre_rst_b", rd1[1], 64'h1234);
    #2 Reset = 1'b1;
    #1;
    chk("async_rst_a", rd1[0], 64'h0);
    chk("async_rst_b", rd1[1], 64'h0);
    WE = 1; WADDR = 9; WDATA = 64'h5555; ISSUE_EN = 1; ISSUE_ADDR = 12; RADDR2 = 12;
    step();
    settle();
    chk("in_rst_wr_b", rd1[1], 64'h0);
    Reset = 1'b0;
    ISSUE_EN = 0;
    step();
    WE = 0;
    settle();
    chk("post_rst_wr_a", rd1[0], 64'h5555);
    chk("post_rst_wr_b", rd1[1], 64'h5555);
    chk("rst_iss_drop_a", W'(rb2[0]), 64'h0);
    chk("rst_iss_drop_b", W'(rb2[1]), 64'h0);

    // random traffic
    for (int c = 0; c < 10000; c++) begin
      step();
      WE         = 1'($urandom_range(0, 1));
      WADDR      = reg_addr_t'($urandom_range(0, 31));
      WDATA      = {$urandom, $urandom};
      ISSUE_EN   = ($urandom_range(0, 3) == 0);
      ISSUE_ADDR = ($urandom_range(0, 3) == 0) ? WADDR : reg_addr_t'($urandom_range(0, 31));
      RADDR1     = ($urandom_range(0, 3) == 0) ? WADDR : reg_addr_t'($urandom_range(0, 31));
      RADDR2     = ($urandom_range(0, 7) == 0) ? RADDR1 : reg_addr_t'($urandom_range(0, 31));
      if ($urandom_range(0, 999) == 0) begin
        #2 Reset = 1'b1;
        #1 Reset = 1'b0;
      end
    end

    step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
